imm_gen: RTL and testbench

IMM_GEN -- requirements
Module: imm_gen

---
 rtl/imm_gen_pkg.sv | 26 ++
 rtl/imm_gen.sv | 40 ++++
 tb/tb_imm_gen.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared CPU constants: immediate format codes and helpers
package imm_gen_pkg;

    localparam int XLEN = 32;

    // Format codes shared by the instruction decoder and imm_gen
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    function automatic logic sel_is_legal(input logic [2:0] sel);
        return (sel >= FMT_I) && (sel <= FMT_J);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate generator: combinational select plus one output register
module imm_gen
    import imm_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [24:0]      inst_in,
    input  logic [2:0]       imm_sel,
    output logic [XLEN-1:0]  imm_out,
    output logic [XLEN-1:0]  imm_out_q,
    output logic             sel_illegal
);

    // Re-index so field slices read exactly as instruction bit numbers
    logic [31:7] ins;
    assign ins = inst_in;

    always_comb begin
        imm_out = '0;
        case (imm_sel)
            FMT_I:   imm_out = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm_out = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm_out = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm_out = {ins[31:12], 12'b0};
            FMT_J:   imm_out = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm_out = '0;
        endcase
    end

    assign sel_illegal = !sel_is_legal(imm_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_out_q <= '0;
        end else begin
            imm_out_q <= imm_out;
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// tb/tb_imm_gen.sv - scoreboard bench for imm_gen with random and directed vectors
module tb_imm_gen;

    typedef struct {
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] inst_in = '0;
    logic [2:0]  imm_sel = '0;
    logic [31:0] imm_out;
    logic [31:0] imm_out_q;
    logic        sel_illegal;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    logic rst_at_edge = 1'b1;

    imm_gen dut (
        .clk(clk),
        .rst(rst),
        .inst_in(inst_in),
        .imm_sel(imm_sel),
        .imm_out(imm_out),
        .imm_out_q(imm_out_q),
        .sel_illegal(sel_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_at_edge = rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint bit_at(input logic [24:0] x, input int n);
        return longint'(x[n-7]);
    endfunction

    // Reference: immediate value as a signed integer built from weighted instruction bits
    function automatic exp_t model(input logic [24:0] x, input logic [2:0] sel);
        exp_t e;
        longint v = 0;
        e.illegal = 1'b0;
        case (sel)
            3'd1: begin
                v = -2048 * bit_at(x, 31);
                for (int k = 20; k <= 30; k++) v += bit_at(x, k) << (k - 20);
            end
            3'd2: begin
                v = -2048 * bit_at(x, 31);
                for (int k = 25; k <= 30; k++) v += bit_at(x, k) << (k - 20);
                for (int k = 7; k <= 11; k++) v += bit_at(x, k) << (k - 7);
            end
            3'd3: begin
                v = -4096 * bit_at(x, 31) + 2048 * bit_at(x, 7);
                for (int k = 25; k <= 30; k++) v += bit_at(x, k) << (k - 20);
                for (int k = 8; k <= 11; k++) v += bit_at(x, k) << (k - 7);
            end
            3'd4: begin
                for (int k = 12; k <= 31; k++) v += bit_at(x, k) << k;
            end
            3'd5: begin
                v = -(longint'(1) << 20) * bit_at(x, 31) + 2048 * bit_at(x, 20);
                for (int k = 12; k <= 19; k++) v += bit_at(x, k) << k;
                for (int k = 21; k <= 30; k++) v += bit_at(x, k) << (k - 20);
            end
            default: begin
                v = 0;
                e.illegal = 1'b1;
            end
        endcase
        e.imm = 32'(v);
        return e;
    endfunction

    function automatic logic [24:0] setb(input logic [24:0] x, input int n, input logic b);
        logic [24:0] r = x;
        r[n-7] = b;
        return r;
    endfunction

    function automatic logic [24:0] enc_i(input logic [11:0] imm);
        logic [24:0] x = 25'($urandom);
        for (int i = 0; i < 12; i++) x = setb(x, 20 + i, imm[i]);
        return x;
    endfunction

    function automatic logic [24:0] enc_s(input logic [11:0] imm);
        logic [24:0] x = 25'($urandom);
        for (int i = 0; i < 5; i++) x = setb(x, 7 + i, imm[i]);
        for (int i = 5; i < 12; i++) x = setb(x, 20 + i, imm[i]);
        return x;
    endfunction

    function automatic logic [24:0] enc_b(input logic [12:0] imm);
        logic [24:0] x = 25'($urandom);
        for (int i = 1; i < 5; i++) x = setb(x, 7 + i, imm[i]);
        for (int i = 5; i < 11; i++) x = setb(x, 20 + i, imm[i]);
        x = setb(x, 7, imm[11]);
        x = setb(x, 31, imm[12]);
        return x;
    endfunction

    function automatic logic [24:0] enc_u(input logic [19:0] imm);
        logic [24:0] x = 25'($urandom);
        for (int i = 0; i < 20; i++) x = setb(x, 12 + i, imm[i]);
        return x;
    endfunction

    function automatic logic [24:0] enc_j(input logic [20:0] imm);
        logic [24:0] x = 25'($urandom);
        for (int i = 1; i < 11; i++) x = setb(x, 20 + i, imm[i]);
        for (int i = 12; i < 20; i++) x = setb(x, i, imm[i]);
        x = setb(x, 20, imm[11]);
        x = setb(x, 31, imm[20]);
        return x;
    endfunction

    task automatic apply(input logic [24:0] x, input logic [2:0] sel, input exp_t e);
        @(posedge clk);
        #1;
        inst_in = x;
        imm_sel = sel;
        sb.push_back(e);
    endtask

    task automatic directed(input logic [24:0] x, input logic [2:0] sel,
                            input logic [31:0] imm, input logic ill);
        exp_t e;
        e.imm = imm;
        e.illegal = ill;
        apply(x, sel, e);
    endtask

    // Monitor: checks the combinational outputs of each issued vector, and the
    // register against the vector that was on the inputs at the last rising edge
    initial begin : monitor
        exp_t cur;
        exp_t nxt;
        cur.imm = '0;
        cur.illegal = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || rst_at_edge) check("imm_out_q_reset", imm_out_q, 32'h0);
            else                    check("imm_out_q", imm_out_q, cur.imm);
            if (sb.size() > 0) begin
                nxt = sb.pop_front();
                check("imm_out", imm_out, nxt.imm);
                check("sel_illegal", 32'(sel_illegal), 32'(nxt.illegal));
                cur = nxt;
            end
        end
    end

    initial begin : stimulus
        logic [24:0] x;
        logic [2:0]  s;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        directed(enc_i(12'h800), 3'd1, 32'hFFFFF800, 1'b0);
        directed(enc_i(12'h7FF), 3'd1, 32'h000007FF, 1'b0);
        directed(enc_s(12'hF9C), 3'd2, 32'hFFFFFF9C, 1'b0);
        directed(enc_s(12'h801), 3'd2, 32'hFFFFF801, 1'b0);
        directed(enc_b(13'h0800), 3'd3, 32'h00000800, 1'b0);
        directed(enc_b(13'h1F9C), 3'd3, 32'hFFFFFF9C, 1'b0);
        directed(enc_j(21'h080000), 3'd5, 32'h00080000, 1'b0);
        directed(enc_j(21'h180000), 3'd5, 32'hFFF80000, 1'b0);
        directed(enc_j(21'h000001), 3'd5, 32'h00000000, 1'b0);
        directed(enc_u(20'h7FFFF), 3'd4, 32'h7FFFF000, 1'b0);
        directed(25'($urandom), 3'd0, 32'h0, 1'b1);
        directed(25'($urandom), 3'd7, 32'h0, 1'b1);
        directed(25'($urandom), 3'd6, 32'h0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            x = 25'($urandom);
            s = 3'($urandom_range(0, 7));
            apply(x, s, model(x, s));
        end

        // Asynchronous reset mid-cycle, then release with FFFFF800 on the output
        directed(enc_i(12'h800), 3'd1, 32'hFFFFF800, 1'b0);
        #2 rst = 1'b1;
        #1 check("imm_out_q_async_reset", imm_out_q, 32'h0);
        check("imm_out_during_reset", imm_out, 32'hFFFFF800);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("imm_out_q_after_release", imm_out_q, 32'hFFFFF800);

        for (int n = 0; n < 50; n++) begin
            x = 25'($urandom);
            s = 3'($urandom_range(1, 5));
            apply(x, s, model(x, s));
        end

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
